// File: rtl/frame_bram_ctrl.sv
// Frame capture/readout controller: grabs one VGA frame as RGB332 into BRAM, then scans it for display.
// Byte readout (valid/ready, tx_data held while stalled) exists only when FRAME_BRAM_TX_EN is defined.
module frame_bram_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 400,
  parameter int ADDR_W   = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              store_bram,
  input  logic              send_req,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic              vsync,
  input  logic [23:0]       pixel_in,
  input  logic [7:0]        bram_dout,
  output logic [1:0]        bram_state,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [7:0]        bram_din,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_done
);
  typedef enum logic [1:0] {
    BRAM_IDLE     = 2'b00,
    CAPTURE_FRAME = 2'b01,
    WRITING_FRAME = 2'b10,
    READING_FRAME = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
  localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vsync_q;
  logic              fs, in_window;
  logic              unused_in;

  assign fs        = vsync_q & ~vsync;
  assign in_window = (hcount < H_LIM) && (vcount < V_LIM);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (!store_bram) begin
      state_d = BRAM_IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        BRAM_IDLE: state_d = CAPTURE_FRAME;
        CAPTURE_FRAME: begin
          if (fs) begin
            state_d = WRITING_FRAME;
            addr_d  = '0;
          end
        end
        WRITING_FRAME: begin
          if (in_window) begin
            if (addr_q == LAST_ADDR) begin
              state_d = READING_FRAME;
              addr_d  = '0;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
        READING_FRAME: begin
          // display scan pointer keeps running even while a readout owns bram_addr
          if (fs)             addr_d = '0;
          else if (in_window) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BRAM_IDLE;
      addr_q  <= '0;
      vsync_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      vsync_q <= vsync;
    end
  end

  assign bram_state = state_q;
  assign bram_we    = (state_q == WRITING_FRAME) && store_bram && in_window;
  assign bram_din   = bram_we ? {pixel_in[23:21], pixel_in[15:13], pixel_in[7:6]} : 8'h00;

`ifdef FRAME_BRAM_TX_EN
  logic              tx_active_q, tx_active_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_fresh_q, tx_fresh_d;
  logic              tx_done_q, tx_done_d;
  logic [ADDR_W-1:0] tx_addr_q, tx_addr_d;
  logic [7:0]        tx_hold_q, tx_hold_d;
  logic              tx_accept;

  assign tx_accept = tx_valid_q & tx_ready;

  always_comb begin
    tx_active_d = tx_active_q;
    tx_valid_d  = tx_valid_q;
    tx_addr_d   = tx_addr_q;
    tx_fresh_d  = 1'b0;
    tx_done_d   = 1'b0;
    // first valid cycle takes the byte straight from BRAM; later stall cycles replay the copy
    tx_hold_d   = tx_fresh_q ? bram_dout : tx_hold_q;
    if (!store_bram) begin
      tx_active_d = 1'b0;
      tx_valid_d  = 1'b0;
    end else if (tx_active_q) begin
      if (tx_accept) begin
        tx_valid_d = 1'b0;
        if (tx_addr_q == LAST_ADDR) begin
          tx_active_d = 1'b0;
          tx_done_d   = 1'b1;
        end else begin
          tx_addr_d = tx_addr_q + ADDR_W'(1);
        end
      end else if (!tx_valid_q) begin
        tx_valid_d = 1'b1;
        tx_fresh_d = 1'b1;
      end
    end else if (send_req && (state_q == READING_FRAME)) begin
      tx_active_d = 1'b1;
      tx_addr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_active_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_fresh_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_addr_q   <= '0;
      tx_hold_q   <= 8'h00;
    end else begin
      tx_active_q <= tx_active_d;
      tx_valid_q  <= tx_valid_d;
      tx_fresh_q  <= tx_fresh_d;
      tx_done_q   <= tx_done_d;
      tx_addr_q   <= tx_addr_d;
      tx_hold_q   <= tx_hold_d;
    end
  end

  assign bram_addr = tx_active_q ? tx_addr_q : addr_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_valid_q ? (tx_fresh_q ? bram_dout : tx_hold_q) : 8'h00;
  assign tx_done   = tx_done_q;
  assign unused_in = ^{pixel_in[20:16], pixel_in[12:8], pixel_in[5:0]};
`else
  assign bram_addr = addr_q;
  assign tx_valid  = 1'b0;
  assign tx_data   = 8'h00;
  assign tx_done   = 1'b0;
  assign unused_in = ^{pixel_in[20:16], pixel_in[12:8], pixel_in[5:0], send_req, tx_ready, bram_dout};
`endif

endmodule
